// File: rtl/fifo_drain_skid_if.sv
// Handshake bundle for fifo_drain_skid: the fifo read side (empty/data/rd_en)
// and the outgoing valid/ready stream. The drain stage is the master of the
// bundle; the slave view belongs to whatever sits around it (fifo + sink).
interface fifo_drain_skid_if #(
    parameter int unsigned FIFO_WIDTH = 8
);
    logic                  fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [FIFO_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_drain_skid.sv
// Downstream read stage for the fifo block. Drains the fifo whenever it is
// non-empty and re-presents the words as a valid/ready stream. The fifo has a
// registered read port (data one cycle after rd_en), so a two-entry skid
// buffer absorbs the word that is already in flight when the sink stalls.
// A continuously ready sink sees one word per clock with no bubbles.
module fifo_drain_skid #(
    parameter int unsigned FIFO_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rstN,
    fifo_drain_skid_if.master    bus,
    output logic [CNT_WIDTH-1:0] rd_count
);

    // Buffer occupancy states; encoding equals the number of buffered words.
    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StTwo   = 2'd2;

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [FIFO_WIDTH-1:0] head_q, head_d;
    logic [FIFO_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  valid;
    logic                  pop;
    logic                  capture;
    logic [2:0]            pending;
    logic                  issue;

    // Handshake terms and read-issue decision.
    always_comb begin
        valid   = (occ_q != StEmpty);
        pop     = valid & bus.m_ready;
        // The word requested last cycle lands this edge.
        capture = inflight_q;
        // Words already owned by this stage (buffered + in flight).
        pending = {1'b0, occ_q} + {2'b00, inflight_q};
        // A new read may only be issued if its word is guaranteed a slot:
        // pending - pop <= 1, rewritten without subtraction. Held low in reset.
        issue   = rstN & ~bus.fifo_empty & (pending <= ({2'b00, pop} + 3'd1));
    end

    // Occupancy FSM and skid-buffer data movement (head is the oldest word).
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            StEmpty: begin
                // pop is impossible here since valid is low.
                if (capture) begin
                    head_d = bus.fifo_data;
                    occ_d  = StOne;
                end
            end
            StOne: begin
                case ({capture, pop})
                    2'b11: head_d = bus.fifo_data;
                    2'b10: begin
                        tail_d = bus.fifo_data;
                        occ_d  = StTwo;
                    end
                    2'b01: occ_d = StEmpty;
                    default: ;
                endcase
            end
            StTwo: begin
                // capture without pop cannot happen: the issue rule forbids it.
                if (pop) begin
                    head_d = tail_q;
                    if (capture) begin
                        tail_d = bus.fifo_data;
                    end else begin
                        occ_d = StOne;
                    end
                end
            end
            default: occ_d = StEmpty;
        endcase
    end

    // Delivered-word counter; wraps naturally at 2^CNT_WIDTH.
    always_comb begin
        cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
    end

    // State registers; reset discards buffered and in-flight words.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            occ_q      <= StEmpty;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= issue;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.fifo_rd_en = issue;
    assign bus.m_valid    = valid;
    assign bus.m_data     = head_q;
    assign rd_count       = cnt_q;

endmodule
